// File: rtl/ppt_sequencer.sv
// rtl/ppt_sequencer.sv - burst sequencer gating the programmable pulse train generator
//
// Turns a software run level into a gated generator enable with a start delay
// and an optional finite pulse count.
//
// Ports:
//   clk          divided clock, shared with pulse generator/counter
//   rst_n        asynchronous active-low reset
//   run_req      run level from register map (asynchronous to clk)
//   start_delay  clk cycles to wait after start before enabling generator
//   pulse_target pulses per burst, 0 = continuous
//   pulse_in     pulse generator output (synchronous to clk)
//   gen_run      run enable to pulse generator and pulse counter
//   busy         high while a burst is in progress (delay, run, drain)
//   done         burst completed, held until run_req deasserts
//   pulses_sent  rising edges of pulse_in counted in current burst
module ppt_sequencer #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run_req,
    input  logic [CNT_W-1:0] start_delay,
    input  logic [CNT_W-1:0] pulse_target,
    input  logic             pulse_in,
    output logic             gen_run,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] pulses_sent
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        DELAY = 3'd1,
        RUN   = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state, state_n;
    logic             sync1, run_s, run_s_q;
    logic [2:0]       sync_vld;
    logic             pulse_q;
    logic [CNT_W-1:0] dcnt, dcnt_n;
    logic [CNT_W-1:0] tgt, tgt_n;
    logic [CNT_W-1:0] cnt_n;
    logic [CNT_W-1:0] cnt_inc;
    logic             start, pedge;

    // sync_vld tracks how many synchronizer stages hold a real sample since
    // reset. The edge detector is only trusted once run_s_q is real, so a
    // run_req already high across reset is not mistaken for a fresh 0->1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1    <= 1'b0;
            run_s    <= 1'b0;
            run_s_q  <= 1'b0;
            sync_vld <= 3'b000;
            pulse_q  <= 1'b0;
        end else begin
            sync1    <= run_req;
            run_s    <= sync1;
            run_s_q  <= run_s;
            sync_vld <= {sync_vld[1:0], 1'b1};
            pulse_q  <= pulse_in;
        end
    end

    assign start   = run_s & ~run_s_q & sync_vld[2];
    assign pedge   = pulse_in & ~pulse_q;
    assign cnt_inc = pulses_sent + ONE;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            dcnt        <= '0;
            tgt         <= '0;
            pulses_sent <= '0;
            gen_run     <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            state       <= state_n;
            dcnt        <= dcnt_n;
            tgt         <= tgt_n;
            pulses_sent <= cnt_n;
            gen_run     <= (state_n == RUN) || (state_n == DRAIN);
            busy        <= (state_n == DELAY) || (state_n == RUN) || (state_n == DRAIN);
            done        <= (state_n == DONE);
        end
    end

    always_comb begin
        state_n = state;
        dcnt_n  = dcnt;
        tgt_n   = tgt;
        cnt_n   = pulses_sent;
        case (state)
            IDLE: begin
                if (start) begin
                    tgt_n   = pulse_target;
                    dcnt_n  = start_delay;
                    cnt_n   = '0;
                    state_n = DELAY;
                end
            end
            DELAY: begin
                if (!run_s) begin
                    state_n = IDLE;
                end else if (dcnt == '0) begin
                    state_n = RUN;
                end else begin
                    dcnt_n = dcnt - ONE;
                end
            end
            RUN: begin
                // Abort wins over counting so an aborted burst never reports
                // a pulse that coincided with the abort.
                if (!run_s) begin
                    state_n = IDLE;
                end else if (pedge) begin
                    if (tgt == '0) begin
                        if (pulses_sent != '1) begin
                            cnt_n = cnt_inc;
                        end
                    end else begin
                        cnt_n = cnt_inc;
                        if (cnt_inc == tgt) begin
                            state_n = DRAIN;
                        end
                    end
                end
            end
            DRAIN: begin
                // Keep the generator enabled until the last pulse has ended.
                if (!run_s) begin
                    state_n = IDLE;
                end else if (!pulse_in) begin
                    state_n = DONE;
                end
            end
            DONE: begin
                if (!run_s) begin
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_ppt_sequencer.sv
// tb/tb_ppt_sequencer.sv - self-checking bench for ppt_sequencer
module tb_ppt_sequencer;

    localparam int CNT_W = 16;

    logic             clk;
    logic             rst_n;
    logic             run_req;
    logic [CNT_W-1:0] start_delay;
    logic [CNT_W-1:0] pulse_target;
    logic             pulse_in;
    logic             gen_run;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] pulses_sent;

    ppt_sequencer #(.CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .run_req      (run_req),
        .start_delay  (start_delay),
        .pulse_target (pulse_target),
        .pulse_in     (pulse_in),
        .gen_run      (gen_run),
        .busy         (busy),
        .done         (done),
        .pulses_sent  (pulses_sent)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Pulse generator model and monitor: period 10 / width 3 while enabled,
    // or random levels in rand_mode. Counts the rising edges it produces.
    bit rand_mode   = 0;
    int ph          = 0;
    int cyc         = 0;
    int edges       = 0;
    int last_fall   = 0;
    int gr_fall     = 0;
    bit gr_prev     = 0;
    bit seen_gr     = 0;
    bit seen_done   = 0;
    bit prev_pulse;

    initial begin
        pulse_in = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            prev_pulse = pulse_in;
            if (gen_run) begin
                if (rand_mode) begin
                    pulse_in = 1'($urandom_range(0, 1));
                end else begin
                    pulse_in = (ph < 3);
                    ph = (ph + 1) % 10;
                end
            end else begin
                pulse_in = 1'b0;
                ph = 0;
            end
            if (pulse_in && !prev_pulse) edges++;
            if (!pulse_in && prev_pulse) last_fall = cyc;
            if (gr_prev && !gen_run) gr_fall = cyc;
            gr_prev = gen_run;
            if (gen_run) seen_gr = 1;
            if (done) seen_done = 1;
        end
    end

    // Full burst: expected timing and counts come from the burst rules:
    // busy 3 samples after run_req, gen_run d+1 cycles later, t pulses.
    task automatic run_burst(input int d, input int t, input bit chg,
                             input int exp_gap, input int exp_pulses);
        int n;
        int nb;
        start_delay  = CNT_W'(d);
        pulse_target = CNT_W'(t);
        edges = 0;
        @(negedge clk);
        run_req = 1'b1;
        n = 0;
        nb = 0;
        while (!gen_run && n < 200) begin
            @(negedge clk);
            n++;
            if (busy && nb == 0) nb = n;
        end
        check("gen_run_rise_timeout", gen_run, 1);
        check("busy_latency", nb, 3);
        check("run_latency", n - nb, exp_gap);
        check("count_restart", pulses_sent, 0);
        if (chg) begin
            pulse_target = CNT_W'(1);
            start_delay  = '0;
        end
        n = 0;
        while (!done && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check("done_set", done, 1);
        check("pulses_sent", pulses_sent, exp_pulses);
        check("pedges_seen", edges, exp_pulses);
        check("busy_after_done", busy, 0);
        check("gen_run_after_done", gen_run, 0);
        check("gen_run_fall_after_last_pulse", gr_fall - last_fall, 1);
        repeat (4) @(negedge clk);
        check("done_held", done, 1);
        run_req = 1'b0;
        n = 0;
        while (done && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("done_clear_within_3", (n <= 3) && !done, 1);
        check("busy_idle", busy, 0);
        repeat (2) @(negedge clk);
    endtask

    typedef struct {
        int d;
        int t;
        bit chg;
        int exp_gap;
        int exp_pulses;
    } vec_t;

    vec_t tbl[6];

    initial begin
        int n;
        tbl[0] = '{3, 4, 1'b0, 4, 4};
        tbl[1] = '{3, 4, 1'b0, 4, 4};
        tbl[2] = '{0, 1, 1'b0, 1, 1};
        tbl[3] = '{7, 2, 1'b0, 8, 2};
        tbl[4] = '{2, 4, 1'b1, 3, 4};
        tbl[5] = '{5, 6, 1'b0, 6, 6};

        rst_n        = 1'b0;
        run_req      = 1'b0;
        start_delay  = '0;
        pulse_target = '0;
        repeat (3) @(negedge clk);
        check("reset_gen_run", gen_run, 0);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_pulses_sent", pulses_sent, 0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // Table-driven bursts, including a second identical burst and a
        // mid-burst target change that must not affect the burst.
        for (int i = 0; i < 6; i++) begin
            run_burst(tbl[i].d, tbl[i].t, tbl[i].chg, tbl[i].exp_gap, tbl[i].exp_pulses);
        end

        // Continuous mode: 100 pulses, no done, abort holds count.
        start_delay  = '0;
        pulse_target = '0;
        edges = 0;
        seen_done = 0;
        @(negedge clk);
        run_req = 1'b1;
        n = 0;
        while (edges < 100 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        check("cont_pulses_sent", pulses_sent, 100);
        check("cont_gen_run", gen_run, 1);
        check("cont_no_done", seen_done, 0);
        run_req = 1'b0;
        n = 0;
        while (gen_run && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("cont_abort_within_3", (n <= 3) && !gen_run, 1);
        check("cont_count_held", pulses_sent, 100);
        check("cont_edges", edges, 100);
        repeat (3) @(negedge clk);

        // Abort during DELAY.
        start_delay  = CNT_W'(50);
        pulse_target = CNT_W'(3);
        seen_gr = 0;
        seen_done = 0;
        @(negedge clk);
        run_req = 1'b1;
        repeat (10) @(negedge clk);
        run_req = 1'b0;
        repeat (6) @(negedge clk);
        check("delay_abort_no_gen_run", seen_gr, 0);
        check("delay_abort_done", done, 0);
        check("delay_abort_busy", busy, 0);
        repeat (2) @(negedge clk);

        // Abort coincident with the final pulse edge of a 2-pulse burst:
        // run_s falls exactly at the edge that sees the second pedge.
        start_delay  = CNT_W'(1);
        pulse_target = CNT_W'(2);
        edges = 0;
        seen_done = 0;
        @(negedge clk);
        run_req = 1'b1;
        n = 0;
        while (!gen_run && n < 50) begin
            @(negedge clk);
            n++;
        end
        repeat (8) @(negedge clk);
        run_req = 1'b0;
        repeat (6) @(negedge clk);
        check("coinc_abort_done", seen_done, 0);
        check("coinc_abort_busy", busy, 0);
        check("coinc_abort_gen_run", gen_run, 0);
        check("coinc_abort_count", pulses_sent, 1);
        check("coinc_abort_edges", edges, 2);
        repeat (2) @(negedge clk);

        // Asynchronous reset mid-pulse in RUN, then no restart without toggle.
        start_delay  = '0;
        pulse_target = '0;
        edges = 0;
        @(negedge clk);
        run_req = 1'b1;
        n = 0;
        while (edges < 3 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("pre_reset_pulse_high", pulse_in, 1);
        #1;
        rst_n = 1'b0;
        #1;
        check("async_rst_gen_run", gen_run, 0);
        check("async_rst_busy", busy, 0);
        check("async_rst_done", done, 0);
        check("async_rst_pulses_sent", pulses_sent, 0);
        @(negedge clk);
        rst_n = 1'b1;
        seen_gr = 0;
        repeat (20) @(negedge clk);
        check("no_start_after_reset", seen_gr, 0);
        check("no_busy_after_reset", busy, 0);
        run_req = 1'b0;
        repeat (5) @(negedge clk);
        run_req = 1'b1;
        n = 0;
        while (!busy && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("start_after_toggle", n, 3);
        run_req = 1'b0;
        repeat (6) @(negedge clk);

        // Randomized bursts with random generator levels.
        rand_mode = 1;
        for (int i = 0; i < 8; i++) begin
            int d;
            int t;
            d = int'($urandom_range(0, 8));
            t = int'($urandom_range(1, 6));
            run_burst(d, t, 1'($urandom_range(0, 1)), d + 1, t);
        end
        rand_mode = 0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
